instr_fetch: RTL and testbench



---
 rtl/instr_fetch.sv | 94 +++++++++
 tb/tb_instr_fetch.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between program counter and a 1-cycle synchronous ROM,
// buffering PC-tagged instruction words in a small FIFO drained by decode.
// Ports:
//   clk, n_reset   clock (rising edge) and asynchronous active-low reset
//   pc_count       current PC from the program counter
//   pc_en          advance PC; high exactly when a fetch is issued
//   rom_addr       ROM read address (combinationally pc_count)
//   rom_data       ROM read data, valid the cycle after rom_addr was issued
//   stall          blocks new fetch issue only
//   flush          drops buffered and in-flight instructions
//   instr/instr_pc head instruction word and its PC
//   instr_valid    FIFO non-empty
//   instr_ready    decode accepts the head this cycle
//   fifo_level     current FIFO occupancy
module instr_fetch #(
    parameter int ADDR_WIDTH  = 3,
    parameter int INSTR_WIDTH = 8,
    parameter int FIFO_DEPTH  = 2
) (
    input  logic                          clk,
    input  logic                          n_reset,
    input  logic [ADDR_WIDTH-1:0]         pc_count,
    output logic                          pc_en,
    output logic [ADDR_WIDTH-1:0]         rom_addr,
    input  logic [INSTR_WIDTH-1:0]        rom_data,
    input  logic                          stall,
    input  logic                          flush,
    output logic [INSTR_WIDTH-1:0]        instr,
    output logic [ADDR_WIDTH-1:0]         instr_pc,
    output logic                          instr_valid,
    input  logic                          instr_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 2;

    logic [INSTR_WIDTH-1:0] data_mem [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  pc_mem   [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr;
    logic [PW-1:0]          rd_ptr;
    logic [PW:0]            level;
    logic                   inflight;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   pop;
    logic                   wr;
    logic [CW-1:0]          credit;

    assign rom_addr    = pc_count;
    assign instr_valid = level != '0;
    assign instr       = data_mem[rd_ptr];
    assign instr_pc    = pc_mem[rd_ptr];
    assign fifo_level  = level;

    // Slots already promised (buffered + in flight) minus the one freed by
    // this cycle's pop; issuing only below depth reserves a slot per fetch.
    always_comb begin
        pop    = instr_valid & instr_ready;
        wr     = inflight & ~flush;
        credit = CW'(level) + CW'(inflight) - CW'(pop);
        pc_en  = n_reset & ~stall & ~flush & (credit < CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            inflight <= 1'b0;
            pc_q     <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else if (flush) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= pc_en;
            if (pc_en) pc_q <= pc_count;
            if (wr) begin
                data_mem[wr_ptr] <= rom_data;
                pc_mem[wr_ptr]   <= pc_q;
                wr_ptr           <= wr_ptr + PW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            level <= level + (PW+1)'(wr) - (PW+1)'(pop);
        end
    end

    // The issue credit guarantees a free slot for every returning word.
    assert property (@(posedge clk) disable iff (!n_reset) wr |-> int'(level) < FIFO_DEPTH);
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed stimulus with a queue-based reference model for instr_fetch.
module tb_instr_fetch;
    localparam int AW = 3;
    localparam int IW = 8;
    localparam int D  = 2;

    logic          clk = 1'b0;
    logic          n_reset = 1'b0;
    logic [AW-1:0] pc_count;
    logic          pc_en;
    logic [AW-1:0] rom_addr;
    logic [IW-1:0] rom_data;
    logic          stall = 1'b0;
    logic          flush = 1'b0;
    logic [IW-1:0] instr;
    logic [AW-1:0] instr_pc;
    logic          instr_valid;
    logic          instr_ready = 1'b1;
    logic [1:0]    fifo_level;
    logic          load = 1'b0;
    logic [AW-1:0] load_pc = '0;
    logic [IW-1:0] rom_arr [8];

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [AW+IW-1:0] q[$];
    int               pend = 0;
    logic [AW-1:0]    pend_pc = '0;

    instr_fetch #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW), .FIFO_DEPTH(D)) dut (
        .clk(clk), .n_reset(n_reset), .pc_count(pc_count), .pc_en(pc_en),
        .rom_addr(rom_addr), .rom_data(rom_data), .stall(stall), .flush(flush),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_arr[rom_addr];

    // Program counter with controller redirect.
    always @(posedge clk or negedge n_reset) begin
        if (!n_reset) pc_count <= '0;
        else if (load) pc_count <= load_pc;
        else if (pc_en) pc_count <= pc_count + 3'd1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: queue of {pc, word} plus one pending ROM request.
    always @(negedge clk) begin
        int exp_pop;
        int exp_en;
        logic [AW+IW-1:0] head;
        if (!n_reset) begin
            q.delete();
            pend = 0;
            chk("rst_valid", 32'(instr_valid), 0);
            chk("rst_level", 32'(fifo_level), 0);
            chk("rst_pc_en", 32'(pc_en), 0);
            chk("rst_instr", 32'(instr), 0);
            chk("rst_instr_pc", 32'(instr_pc), 0);
        end else begin
            exp_pop = (q.size() != 0 && instr_ready) ? 1 : 0;
            exp_en  = (!stall && !flush && (q.size() + pend - exp_pop < D)) ? 1 : 0;
            chk("pc_en", 32'(pc_en), 32'(exp_en));
            chk("rom_addr", 32'(rom_addr), 32'(pc_count));
            chk("valid", 32'(instr_valid), (q.size() != 0) ? 1 : 0);
            chk("level", 32'(fifo_level), 32'(q.size()));
            if (q.size() != 0) begin
                head = q[0];
                chk("instr", 32'(instr), 32'(head[IW-1:0]));
                chk("instr_pc", 32'(instr_pc), 32'(head[AW+IW-1:IW]));
            end
            if (flush) begin
                q.delete();
                pend = 0;
            end else begin
                if (pend != 0) q.push_back({pend_pc, rom_arr[pend_pc]});
                if (exp_pop != 0) void'(q.pop_front());
                pend    = exp_en;
                pend_pc = pc_count;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Leaves the bench at cycle 0 (reset just released), outputs settled.
    task automatic start(input logic rdy);
        n_reset = 1'b0;
        stall = 1'b0;
        flush = 1'b0;
        load = 1'b0;
        instr_ready = rdy;
        step();
        step();
        n_reset = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 8; i++) rom_arr[i] = 8'hA0 + 8'(i);

        // Full-throughput stream with PC wrap.
        start(1'b1);
        chk("t1_pc_en_c0", 32'(pc_en), 1);
        chk("t1_addr_c0", 32'(rom_addr), 0);
        step(); step(); #1;
        chk("t1_valid_c2", 32'(instr_valid), 1);
        chk("t1_instr_c2", 32'(instr), 32'hA0);
        chk("t1_pc_c2", 32'(instr_pc), 0);
        chk("t1_level_c2", 32'(fifo_level), 1);
        repeat (8) step();
        #1;
        chk("t1_wrap_instr", 32'(instr), 32'hA0);
        chk("t1_wrap_pc", 32'(instr_pc), 0);

        // Decode not ready: fill, hold, then drain with reissue.
        start(1'b0);
        step(); step(); #1;
        chk("t2_pc_en_c2", 32'(pc_en), 0);
        step(); #1;
        chk("t2_level_c3", 32'(fifo_level), 2);
        chk("t2_instr_c3", 32'(instr), 32'hA0);
        chk("t2_pc_en_c3", 32'(pc_en), 0);
        step();
        instr_ready = 1'b1;
        #1;
        chk("t2_reissue", 32'(pc_en), 1);
        chk("t2_reissue_addr", 32'(rom_addr), 2);
        step(); #1;
        chk("t2_instr_c5", 32'(instr), 32'hA1);
        chk("t2_pc_c5", 32'(instr_pc), 1);

        // Stall after issue at PC 3.
        start(1'b1);
        repeat (4) step();
        stall = 1'b1;
        #1;
        chk("t3_pc_en_stall", 32'(pc_en), 0);
        step(); #1;
        chk("t3_pc3_landed", 32'(instr_pc), 3);
        chk("t3_instr3", 32'(instr), 32'hA3);
        step(); #1;
        chk("t3_empty", 32'(instr_valid), 0);
        step();
        stall = 1'b0;
        #1;
        chk("t3_resume", 32'(pc_en), 1);
        chk("t3_resume_addr", 32'(rom_addr), 4);
        repeat (3) step();

        // Flush after issue at PC 5 with redirect to PC 2.
        start(1'b1);
        repeat (6) step();
        flush = 1'b1;
        load = 1'b1;
        load_pc = 3'd2;
        #1;
        chk("t4_level_pre", 32'(fifo_level), 1);
        chk("t4_pc_en_flush", 32'(pc_en), 0);
        step();
        flush = 1'b0;
        load = 1'b0;
        #1;
        chk("t4_level_post", 32'(fifo_level), 0);
        chk("t4_addr_post", 32'(rom_addr), 2);
        step(); #1;
        chk("t4_pc5_dropped", 32'(instr_valid), 0);
        step(); #1;
        chk("t4_new_pc", 32'(instr_pc), 2);
        chk("t4_new_instr", 32'(instr), 32'hA2);

        // Flush coincident with pop and ROM return.
        start(1'b1);
        repeat (3) step();
        flush = 1'b1;
        #1;
        chk("t5_head_pc", 32'(instr_pc), 1);
        step();
        flush = 1'b0;
        #1;
        chk("t5_empty", 32'(instr_valid), 0);
        chk("t5_addr", 32'(rom_addr), 3);
        step(); step(); #1;
        chk("t5_pc3", 32'(instr_pc), 3);
        chk("t5_instr3", 32'(instr), 32'hA3);
        step(); #1;
        chk("t5_pc4", 32'(instr_pc), 4);

        // Asynchronous reset mid-stream.
        start(1'b1);
        repeat (4) step();
        #1;
        chk("t6_level_pre", 32'(fifo_level), 1);
        n_reset = 1'b0;
        #1;
        chk("t6_valid", 32'(instr_valid), 0);
        chk("t6_level", 32'(fifo_level), 0);
        chk("t6_instr", 32'(instr), 0);
        chk("t6_pc_en", 32'(pc_en), 0);
        step(); step();
        n_reset = 1'b1;
        #1;
        chk("t6_restart_addr", 32'(rom_addr), 0);
        step(); step(); #1;
        chk("t6_restart_pc", 32'(instr_pc), 0);
        chk("t6_restart_instr", 32'(instr), 32'hA0);
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
